mips_pipe_core: RTL and testbench



---
 rtl/mips_pipe_if.sv | 16 +
 rtl/mips_pipe_core.sv | 190 +++++++++++++++++++
 tb/tb_mips_pipe_core.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pipe_if.sv
// Instruction-in / writeback-out bundle of mips_pipe_core.
// master = instruction source, slave = the pipeline.
interface mips_pipe_if #(parameter int DATA_W = 32);
    logic              instr_valid;
    logic [31:0]       instr;
    logic              instr_ready;
    logic              wb_valid;
    logic [4:0]        wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic              ex_ovf;

    modport master (output instr_valid, instr,
                    input  instr_ready, wb_valid, wb_reg, wb_data, ex_ovf);
    modport slave  (input  instr_valid, instr,
                    output instr_ready, wb_valid, wb_reg, wb_data, ex_ovf);
endinterface

// File: rtl/mips_pipe_core.sv
// 4-stage (ID/EX/MEM/WB) MIPS subset pipeline with local regfile and data memory.
// Define PIPE_FWD_EN for EX/MEM + MEM/WB forwarding; otherwise ID interlocks on RAW hazards.
module mips_pipe_core #(
    parameter int DATA_W    = 32,
    parameter int RF_DEPTH  = 32,
    parameter int MEM_DEPTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    mips_pipe_if.slave bus
);
    localparam int RF_AW  = $clog2(RF_DEPTH);
    localparam int MEM_AW = $clog2(MEM_DEPTH);
    localparam logic [4:0] RMASK = 5'(RF_DEPTH - 1);

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;
    // An all-zero ctrl word is a bubble; we implies dst != 0.
    typedef struct packed {
        logic    vld;
        logic    we;
        logic    lw;
        logic    sw;
        logic    ovf_chk;
        logic    use_imm;
        alu_op_e alu;
        logic [4:0] dst;
    } ctrl_t;

    logic              id_vld_q;
    logic [31:0]       id_instr_q;
    ctrl_t             ex_c_q, mem_c_q, wb_c_q, ex_c_d;
    logic [DATA_W-1:0] ex_a_q, ex_b_q, ex_imm_q;
    logic [4:0]        ex_rs_q, ex_rt_q;
    logic [DATA_W-1:0] mem_alu_q, mem_sd_q, wb_data_q;
    logic              mem_ovf_q;
    logic [DATA_W-1:0] rf_q   [RF_DEPTH];
    logic [DATA_W-1:0] dmem_q [MEM_DEPTH];

    logic [5:0]        op, funct;
    logic [4:0]        rs, rt, rd;
    logic [DATA_W-1:0] imm_x, rs_val, rt_val;
    ctrl_t             dec;
    logic              use_rs, use_rt, ex_hit, stall;

    assign op    = id_instr_q[31:26];
    assign funct = id_instr_q[5:0];
    assign rs    = id_instr_q[25:21] & RMASK;
    assign rt    = id_instr_q[20:16] & RMASK;
    assign rd    = id_instr_q[15:11] & RMASK;
    assign imm_x = {{(DATA_W-16){id_instr_q[15]}}, id_instr_q[15:0]};

    always_comb begin
        dec    = '0;
        use_rs = 1'b0;
        use_rt = 1'b0;
        if (id_vld_q) begin
            dec.vld = 1'b1;
            case (op)
                6'h00: begin
                    use_rs = 1'b1; use_rt = 1'b1; dec.we = 1'b1; dec.dst = rd;
                    case (funct)
                        6'h20:   begin dec.alu = ALU_ADD; dec.ovf_chk = 1'b1; end
                        6'h22:   begin dec.alu = ALU_SUB; dec.ovf_chk = 1'b1; end
                        6'h24:   dec.alu = ALU_AND;
                        6'h25:   dec.alu = ALU_OR;
                        6'h2A:   dec.alu = ALU_SLT;
                        default: begin use_rs = 1'b0; use_rt = 1'b0; dec.we = 1'b0; dec.dst = '0; end
                    endcase
                end
                6'h08: begin use_rs = 1'b1; dec.we = 1'b1; dec.dst = rt; dec.use_imm = 1'b1; dec.ovf_chk = 1'b1; end
                6'h23: begin use_rs = 1'b1; dec.we = 1'b1; dec.lw = 1'b1; dec.dst = rt; dec.use_imm = 1'b1; end
                6'h2B: begin use_rs = 1'b1; use_rt = 1'b1; dec.sw = 1'b1; dec.use_imm = 1'b1; end
                default: ;
            endcase
            if (dec.dst == 5'd0) dec.we = 1'b0;
        end
    end

    // Register read with WB write-through so the retiring value is visible now.
    always_comb begin
        rs_val = rf_q[rs[RF_AW-1:0]];
        rt_val = rf_q[rt[RF_AW-1:0]];
        if (wb_c_q.we && wb_c_q.dst == rs) rs_val = wb_data_q;
        if (wb_c_q.we && wb_c_q.dst == rt) rt_val = wb_data_q;
        if (rs == 5'd0) rs_val = '0;
        if (rt == 5'd0) rt_val = '0;
    end

    assign ex_hit = ex_c_q.we && ((use_rs && rs == ex_c_q.dst) || (use_rt && rt == ex_c_q.dst));
`ifdef PIPE_FWD_EN
    assign stall = ex_hit && ex_c_q.lw;
`else
    logic mem_hit;
    assign mem_hit = mem_c_q.we && ((use_rs && rs == mem_c_q.dst) || (use_rt && rt == mem_c_q.dst));
    assign stall   = ex_hit || mem_hit;
`endif
    assign ex_c_d = stall ? '0 : dec;

    logic [DATA_W-1:0] fa, fb, alu_b, sum, diff, alu_res;
    logic              ovf;
`ifdef PIPE_FWD_EN
    // Loads in MEM are not forwarded; the load-use stall covers that case.
    always_comb begin
        fa = ex_a_q;
        fb = ex_b_q;
        if (mem_c_q.we && !mem_c_q.lw && mem_c_q.dst == ex_rs_q) fa = mem_alu_q;
        else if (wb_c_q.we && wb_c_q.dst == ex_rs_q)             fa = wb_data_q;
        if (mem_c_q.we && !mem_c_q.lw && mem_c_q.dst == ex_rt_q) fb = mem_alu_q;
        else if (wb_c_q.we && wb_c_q.dst == ex_rt_q)             fb = wb_data_q;
    end
`else
    assign fa = ex_a_q;
    assign fb = ex_b_q;
    logic unused_fwd;
    assign unused_fwd = ^{ex_rs_q, ex_rt_q};
`endif

    assign alu_b = ex_c_q.use_imm ? ex_imm_q : fb;
    assign sum   = fa + alu_b;
    assign diff  = fa - alu_b;

    always_comb begin
        case (ex_c_q.alu)
            ALU_SUB: alu_res = diff;
            ALU_AND: alu_res = fa & alu_b;
            ALU_OR:  alu_res = fa | alu_b;
            ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, $signed(fa) < $signed(alu_b)};
            default: alu_res = sum;
        endcase
        if (ex_c_q.alu == ALU_SUB)
            ovf = (fa[DATA_W-1] != alu_b[DATA_W-1]) && (diff[DATA_W-1] != fa[DATA_W-1]);
        else
            ovf = (fa[DATA_W-1] == alu_b[DATA_W-1]) && (sum[DATA_W-1] != fa[DATA_W-1]);
        ovf = ovf && ex_c_q.ovf_chk;
    end

    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_res;
    assign mem_addr = mem_alu_q[MEM_AW-1:0];
    assign mem_res  = mem_c_q.lw ? dmem_q[mem_addr] : mem_alu_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_vld_q   <= 1'b0;
            id_instr_q <= '0;
            ex_c_q     <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_imm_q   <= '0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            mem_c_q    <= '0;
            mem_alu_q  <= '0;
            mem_sd_q   <= '0;
            mem_ovf_q  <= 1'b0;
            wb_c_q     <= '0;
            wb_data_q  <= '0;
            for (int i = 0; i < RF_DEPTH; i++)  rf_q[i]   <= DATA_W'(i);
            for (int i = 0; i < MEM_DEPTH; i++) dmem_q[i] <= DATA_W'(i);
        end else begin
            if (!stall) begin
                id_vld_q <= bus.instr_valid;
                if (bus.instr_valid) id_instr_q <= bus.instr;
            end
            ex_c_q    <= ex_c_d;
            ex_a_q    <= rs_val;
            ex_b_q    <= rt_val;
            ex_imm_q  <= imm_x;
            ex_rs_q   <= rs;
            ex_rt_q   <= rt;
            mem_c_q   <= ex_c_q;
            mem_alu_q <= alu_res;
            mem_sd_q  <= fb;
            mem_ovf_q <= ovf;
            wb_c_q    <= mem_c_q;
            wb_data_q <= mem_res;
            if (wb_c_q.we) rf_q[wb_c_q.dst[RF_AW-1:0]] <= wb_data_q;
            if (mem_c_q.sw) dmem_q[mem_addr] <= mem_sd_q;
        end
    end

    assign bus.instr_ready = !stall;
    assign bus.wb_valid    = wb_c_q.we;
    assign bus.wb_reg      = wb_c_q.dst;
    assign bus.wb_data     = wb_data_q;
    assign bus.ex_ovf      = mem_ovf_q;

    logic unused_bits;
    assign unused_bits = ^{id_instr_q[10:6], wb_c_q};
endmodule

// File: tb/tb_mips_pipe_core.sv
// Directed-vector bench for mips_pipe_core; expected stall counts follow PIPE_FWD_EN.
module tb_mips_pipe_core;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0, errors = 0;
    int   ovf_cnt = 0, rdy_low = 0;
    logic [36:0] wbq[$];

`ifdef PIPE_FWD_EN
    localparam int RAW_STALL = 0, LU_STALL = 1;
`else
    localparam int RAW_STALL = 2, LU_STALL = 2;
`endif

    mips_pipe_if #(.DATA_W(32)) bus();
    mips_pipe_core #(.DATA_W(32), .RF_DEPTH(32), .MEM_DEPTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wb_valid) wbq.push_back({bus.wb_reg, bus.wb_data});
            if (bus.ex_ovf) ovf_cnt <= ovf_cnt + 1;
            if (!bus.instr_ready) rdy_low <= rdy_low + 1;
        end
    end

    function automatic logic [31:0] rtype(input int rs, rt, rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction
    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction
    function automatic logic [36:0] entry(input int i);
        if (i < wbq.size()) return wbq[i];
        return 'x;
    endfunction

    task automatic issue(input logic [31:0] w);
        int n = 0;
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr = w;
        while (!bus.instr_ready && n < 20) begin @(negedge clk); n++; end
        if (!bus.instr_ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout: instr_ready=%b after %0d cycles, required 1", bus.instr_ready, n);
        end
        @(posedge clk);
    endtask
    task automatic idle();
        @(negedge clk);
        bus.instr_valid = 1'b0;
    endtask
    task automatic drain();
        idle();
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        int base;
        logic [36:0] e;
        issue(rtype(1, 2, 3, 6'h20));
        idle();
        repeat (3) @(posedge clk);
        #3;
        checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_wb_valid: got %b expected 1", bus.wb_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid: got %b expected 0", bus.wb_valid); end
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL rst_instr_ready: got %b expected 1", bus.instr_ready); end
        checks++; if (bus.wb_reg !== 5'd0) begin errors++; $display("FAIL rst_wb_reg: got %0d expected 0", bus.wb_reg); end
        checks++; if (bus.wb_data !== 32'd0) begin errors++; $display("FAIL rst_wb_data: got %h expected 0", bus.wb_data); end
        checks++; if (bus.ex_ovf !== 1'b0) begin errors++; $display("FAIL rst_ex_ovf: got %b expected 0", bus.ex_ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        base = wbq.size();
        for (int x = 1; x < 32; x++) issue(rtype(x, 0, x, 6'h20));
        drain();
        checks++; if (wbq.size() != base + 31) begin errors++; $display("FAIL rst_readback_count: got %0d expected 31", wbq.size() - base); end
        for (int x = 1; x < 32; x++) begin
            e = entry(base + x - 1);
            checks++;
            if (e !== {5'(x), 32'(x)}) begin
                errors++; $display("FAIL rst_readback r%0d: got reg %0d data %h expected reg %0d data %h", x, e[36:32], e[31:0], x, x);
            end
        end
    endtask

    task automatic test_single();
        issue(32'h00221820);
        idle();
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL single_e0_wb_valid: got %b expected 0", bus.wb_valid); end
        repeat (2) @(negedge clk);
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL single_e2_wb_valid: got %b expected 0", bus.wb_valid); end
        @(negedge clk);
        checks++;
        if (bus.wb_valid !== 1'b1 || bus.wb_reg !== 5'd3 || bus.wb_data !== 32'd3) begin
            errors++; $display("FAIL single_e3_wb: got valid %b reg %0d data %h expected valid 1 reg 3 data 3", bus.wb_valid, bus.wb_reg, bus.wb_data);
        end
        @(negedge clk);
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL single_e4_wb_valid: got %b expected 0", bus.wb_valid); end
    endtask

    task automatic test_raw_chain();
        int base = wbq.size(), r0 = rdy_low;
        issue(32'h00221820);
        issue(32'h00632020);
        drain();
        checks++; if (rdy_low - r0 != RAW_STALL) begin errors++; $display("FAIL raw_stalls: got %0d expected %0d", rdy_low - r0, RAW_STALL); end
        checks++; if (entry(base) !== {5'd3, 32'd3}) begin errors++; $display("FAIL raw_r3: got %h expected reg 3 data 3", entry(base)); end
        checks++; if (entry(base + 1) !== {5'd4, 32'd6}) begin errors++; $display("FAIL raw_r4: got %h expected reg 4 data 6", entry(base + 1)); end
    endtask

    task automatic test_load_use();
        int base = wbq.size(), r0 = rdy_low;
        issue(32'h8C050004);
        issue(32'h00A13020);
        drain();
        checks++; if (rdy_low - r0 != LU_STALL) begin errors++; $display("FAIL lu_stalls: got %0d expected %0d", rdy_low - r0, LU_STALL); end
        checks++; if (entry(base) !== {5'd5, 32'd4}) begin errors++; $display("FAIL lu_r5: got %h expected reg 5 data 4", entry(base)); end
        checks++; if (entry(base + 1) !== {5'd6, 32'd5}) begin errors++; $display("FAIL lu_r6: got %h expected reg 6 data 5", entry(base + 1)); end
    endtask

    task automatic test_store_load();
        int base = wbq.size();
        issue(32'hAC020007);
        issue(32'h8C080007);
        drain();
        checks++; if (wbq.size() != base + 1) begin errors++; $display("FAIL sl_count: got %0d expected 1", wbq.size() - base); end
        checks++; if (entry(base) !== {5'd8, 32'd2}) begin errors++; $display("FAIL sl_r8: got %h expected reg 8 data 2", entry(base)); end
    endtask

    task automatic test_alu_ops();
        int base = wbq.size();
        logic [36:0] exp_q[5];
        exp_q = '{{5'd10, 32'hFFFFFFFF}, {5'd11, 32'd5}, {5'd12, 32'd31}, {5'd13, 32'd1}, {5'd14, 32'd0}};
        issue(rtype(1, 2, 10, 6'h22));
        issue(rtype(23, 13, 11, 6'h24));
        issue(rtype(17, 14, 12, 6'h25));
        issue(rtype(10, 1, 13, 6'h2A));
        issue(rtype(1, 10, 14, 6'h2A));
        issue(32'hFC000000);
        issue(rtype(1, 2, 15, 6'h21));
        issue(rtype(1, 2, 0, 6'h20));
        drain();
        checks++; if (wbq.size() != base + 5) begin errors++; $display("FAIL alu_count: got %0d expected 5", wbq.size() - base); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (entry(base + i) !== exp_q[i]) begin errors++; $display("FAIL alu_op%0d: got %h expected %h", i, entry(base + i), exp_q[i]); end
        end
    endtask

    task automatic test_overflow();
        int base = wbq.size(), o0;
        issue(itype(6'h08, 0, 31, 16'h8000));
        repeat (16) issue(rtype(31, 31, 31, 6'h20));
        issue(itype(6'h08, 31, 31, 16'hFFFF));
        drain();
        checks++; if (wbq.size() != base + 18) begin errors++; $display("FAIL ovf_setup_count: got %0d expected 18", wbq.size() - base); end
        checks++; if (entry(base + 16) !== {5'd31, 32'h80000000}) begin errors++; $display("FAIL ovf_double: got %h expected reg 31 data 80000000", entry(base + 16)); end
        checks++; if (entry(base + 17) !== {5'd31, 32'h7FFFFFFF}) begin errors++; $display("FAIL ovf_r31: got %h expected reg 31 data 7fffffff", entry(base + 17)); end
        o0 = ovf_cnt;
        base = wbq.size();
        issue(itype(6'h08, 31, 9, 16'h7FFF));
        drain();
        checks++; if (ovf_cnt - o0 != 1) begin errors++; $display("FAIL ovf_cycles: got %0d expected 1", ovf_cnt - o0); end
        checks++; if (entry(base) !== {5'd9, 32'h80007FFE}) begin errors++; $display("FAIL ovf_r9: got %h expected reg 9 data 80007ffe", entry(base)); end
    endtask

    task automatic test_reset_inflight();
        int base, regs[9];
        regs = '{1, 2, 3, 4, 5, 6, 8, 9, 31};
        issue(itype(6'h08, 0, 1, 16'h0055));
        issue(itype(6'h08, 0, 2, 16'h0066));
        issue(itype(6'h08, 0, 3, 16'h0077));
        #2;
        rst_n = 1'b0;
        bus.instr_valid = 1'b0;
        base = wbq.size();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (wbq.size() != base) begin errors++; $display("FAIL inflight_retired: got %0d expected 0", wbq.size() - base); end
        foreach (regs[i]) issue(rtype(regs[i], 0, regs[i], 6'h20));
        issue(itype(6'h23, 0, 20, 16'h0007));
        drain();
        foreach (regs[i]) begin
            checks++;
            if (entry(base + i) !== {5'(regs[i]), 32'(regs[i])}) begin
                errors++; $display("FAIL inflight_r%0d: got %h expected data %0d", regs[i], entry(base + i), regs[i]);
            end
        end
        checks++; if (entry(base + 9) !== {5'd20, 32'd7}) begin errors++; $display("FAIL inflight_mem7: got %h expected reg 20 data 7", entry(base + 9)); end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_single();
        test_raw_chain();
        test_load_use();
        test_store_load();
        test_alu_ops();
        test_overflow();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
